sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter and sequencer for the shared single-port SRAM (15-bit address, 32-bit data). Each requester raises a held request with address, direction and write data. The block grants one requester at a time, drives one SRAM access, waits the SRAM read latency, returns read data and pulses that requester's `done`. It sits between the compute/IO requesters and the `sram` instance and is the only driver of the SRAM control bus.

## Interface
- `READ_LATENCY`, default 1: cycles from the SRAM issue cycle to valid `mem_dataOut`; legal range 1..7.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `moduleEnable`  in  1  when low, no new grant is issued; an in-flight access still completes.
- `memoryEnable1` / `memoryEnable2`  in  1  request from port 1 / port 2; held high until that port's `done` is seen.
- `readWrite1` / `readWrite2`  in  1  1 = write, 0 = read; sampled at grant.
- `Address1` / `Address2`  in  15  word address; sampled at grant.
- `Data1` / `Data2`  in  32  write data; sampled at grant.
- `DataOut1` / `DataOut2`  out  32  last read data returned to that port; held until the next read by that port.
- `done1` / `done2`  out  1  one-cycle completion pulse.
- `mem_enable`  out  1  SRAM access strobe.
- `mem_readWrite`  out  1  SRAM direction (1 = write).
- `mem_address`  out  15  SRAM address.
- `mem_dataIn`  out  32  SRAM write data.
- `mem_dataOut`  in  32  SRAM read data.

## Operation
- States: `S_IDLE`, `S_ISSUE`, `S_WAIT`, `S_DONE`; all registered.
- `S_IDLE`:
  - If `moduleEnable` is high and any request is high, select a grant, latch that port's direction, address and data, and go to `S_ISSUE`.
  - Otherwise stay in `S_IDLE`.
- Grant selection:
  - If only one port requests, that port wins.
  - If both request, the port named by the round-robin pointer `prio` wins.
  - `prio` resets to port 1. In `S_DONE` it is set to the port not served.
- `S_ISSUE`:
  - `mem_enable` = 1 for exactly this cycle; `mem_readWrite`, `mem_address` and `mem_dataIn` come from the latched values.
  - A write goes to `S_DONE`.
  - A read loads the wait counter with `READ_LATENCY`-1 and goes to `S_WAIT`.
- `S_WAIT`:
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mem_dataOut` into the granted port's `DataOut` and go to `S_DONE`.
- `S_DONE`:
  - Granted port's `done` = 1 for this cycle only. Update `prio`. Go to `S_IDLE`.
- Outside `S_ISSUE`:
  - `mem_enable` = 0.
  - `mem_address`, `mem_dataIn` and `mem_readWrite` hold their last latched values; they are 0 after reset.
- Request inputs are ignored outside `S_IDLE`. Changing `Address`/`Data` after grant has no effect.
- A port that keeps its request high through its own `S_DONE` is treated as issuing a new request in the following `S_IDLE`.
- Dropping a request before grant withdraws it without effect. Dropping it after grant does not abort the access.

## Timing
- Reset values: all outputs 0, state `S_IDLE`, `prio` = port 1, counter 0.
- Request sampled high at edge E:
  - `S_ISSUE` occupies cycle E+1.
  - Write: `done` is high in cycle E+2.
  - Read: `done` and the new `DataOut` are both valid in cycle E+2+`READ_LATENCY`.
- Back-to-back accesses: minimum spacing between grants is 3 cycles for writes and 3+`READ_LATENCY` cycles for reads. `S_IDLE` always lasts at least one cycle.
- Reset asserted mid-access:
  - Immediate return to `S_IDLE` with `mem_enable` = 0.
  - No `done` is produced and `DataOut` is cleared.
  - The SRAM write may or may not have occurred.
- `moduleEnable` deasserted during `S_ISSUE`, `S_WAIT` or `S_DONE` has no effect until the next `S_IDLE`.

## Configuration
- `MEMARB_FIXED_PRIORITY_EN`:
  - Defined: `prio` is removed and port 1 always wins simultaneous requests; port 2 may starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Single write on port 1 (`Address1`=0x0010, `Data1`=0xDEADBEEF) -> `mem_enable` high exactly one cycle with `mem_readWrite`=1 and that address/data; `done1` pulses at E+2; `done2` stays 0.
- Port 2 read of 0x0010 with `READ_LATENCY`=1 after the above write -> `DataOut2`=0xDEADBEEF and `done2` at E+3; `DataOut1` unchanged.
- Both ports request continuously (writes) -> grants alternate 1,2,1,2. With `MEMARB_FIXED_PRIORITY_EN` defined, only port 1 is granted.
- `moduleEnable`=0 with both requests high for 10 cycles -> no `mem_enable`, no `done`; raising `moduleEnable` grants port 1 next cycle.
- `READ_LATENCY`=3, port 1 read -> `S_WAIT` lasts 3 cycles; `done1` at E+5; `Address1` changed at E+2 does not affect `mem_address`.
- Reset pulsed during `S_WAIT` -> outputs return to 0 immediately; no `done`; the next request is served normally from port 1 priority.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port SRAM: grant, issue, wait read latency, complete.
// Define MEMARB_FIXED_PRIORITY_EN for fixed port-1 priority instead of round-robin.
module sram_port_arbiter #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        moduleEnable,
   input  logic        memoryEnable1,
   input  logic        memoryEnable2,
   input  logic        readWrite1,
   input  logic        readWrite2,
   input  logic [14:0] Address1,
   input  logic [14:0] Address2,
   input  logic [31:0] Data1,
   input  logic [31:0] Data2,
   output logic [31:0] DataOut1,
   output logic [31:0] DataOut2,
   output logic        done1,
   output logic        done2,
   output logic        mem_enable,
   output logic        mem_readWrite,
   output logic [14:0] mem_address,
   output logic [31:0] mem_dataIn,
   input  logic [31:0] mem_dataOut
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t     state;
   logic       gnt2;
   logic [2:0] cnt;
   logic       pick2;

`ifdef MEMARB_FIXED_PRIORITY_EN
   always_comb begin
      pick2 = memoryEnable2 & ~memoryEnable1;
   end
`else
   logic prio;

   // prio = 1 means port 2 wins a tie.
   always_comb begin
      pick2 = memoryEnable2 & (~memoryEnable1 | prio);
   end
`endif

   // NOTE: all state and outputs use non-blocking assignments so every register
   // samples pre-edge values, which keeps the grant/issue/done timing exact.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         gnt2          <= 1'b0;
         cnt           <= '0;
`ifndef MEMARB_FIXED_PRIORITY_EN
         prio          <= 1'b0;
`endif
         DataOut1      <= '0;
         DataOut2      <= '0;
         done1         <= 1'b0;
         done2         <= 1'b0;
         mem_enable    <= 1'b0;
         mem_readWrite <= 1'b0;
         mem_address   <= '0;
         mem_dataIn    <= '0;
      end else begin
         mem_enable <= 1'b0;
         done1      <= 1'b0;
         done2      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (moduleEnable && (memoryEnable1 || memoryEnable2)) begin
                  gnt2          <= pick2;
                  mem_readWrite <= pick2 ? readWrite2 : readWrite1;
                  mem_address   <= pick2 ? Address2   : Address1;
                  mem_dataIn    <= pick2 ? Data2      : Data1;
                  mem_enable    <= 1'b1;
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mem_readWrite) begin
                  done1 <= ~gnt2;
                  done2 <= gnt2;
                  state <= S_DONE;
               end else begin
                  cnt   <= 3'(READ_LATENCY - 1);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 3'd0) begin
                  if (gnt2) DataOut2 <= mem_dataOut;
                  else      DataOut1 <= mem_dataOut;
                  done1 <= ~gnt2;
                  done2 <= gnt2;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_DONE: begin
`ifndef MEMARB_FIXED_PRIORITY_EN
               prio  <= ~gnt2;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (READ_LATENCY 1 and 3), a behavioural SRAM,
// a transaction-timeline model checked every cycle, and directed literal checks.
module tb_sram_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        me[2], en1[2], en2[2], rw1[2], rw2[2];
   logic [14:0] a1[2], a2[2], maddr[2];
   logic [31:0] d1[2], d2[2], do1[2], do2[2], mdin[2], mdout[2];
   logic        dn1[2], dn2[2], men[2], mrw[2];

   int cyc = 0;
   int vectors = 0;
   int errs = 0;
   bit chk_on = 1'b0;
   int npulse[2] = '{0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rl(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   sram_port_arbiter #(.READ_LATENCY(1)) u_dut_a (
      .clock(clk), .reset(rst), .moduleEnable(me[0]),
      .memoryEnable1(en1[0]), .memoryEnable2(en2[0]),
      .readWrite1(rw1[0]), .readWrite2(rw2[0]),
      .Address1(a1[0]), .Address2(a2[0]), .Data1(d1[0]), .Data2(d2[0]),
      .DataOut1(do1[0]), .DataOut2(do2[0]), .done1(dn1[0]), .done2(dn2[0]),
      .mem_enable(men[0]), .mem_readWrite(mrw[0]), .mem_address(maddr[0]),
      .mem_dataIn(mdin[0]), .mem_dataOut(mdout[0])
   );

   sram_port_arbiter #(.READ_LATENCY(3)) u_dut_b (
      .clock(clk), .reset(rst), .moduleEnable(me[1]),
      .memoryEnable1(en1[1]), .memoryEnable2(en2[1]),
      .readWrite1(rw1[1]), .readWrite2(rw2[1]),
      .Address1(a1[1]), .Address2(a2[1]), .Data1(d1[1]), .Data2(d2[1]),
      .DataOut1(do1[1]), .DataOut2(do2[1]), .done1(dn1[1]), .done2(dn2[1]),
      .mem_enable(men[1]), .mem_readWrite(mrw[1]), .mem_address(maddr[1]),
      .mem_dataIn(mdin[1]), .mem_dataOut(mdout[1])
   );

   // Behavioural SRAM per instance; non-read cycles push a poison word down the read pipe.
   logic [31:0] sram_mem [2][32768];
   logic [31:0] pipe [2][3];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (men[k] && mrw[k]) sram_mem[k][maddr[k]] <= mdin[k];
         pipe[k][0] <= (men[k] && !mrw[k]) ? sram_mem[k][maddr[k]] : 32'hBADC0DE5;
         pipe[k][1] <= pipe[k][0];
         pipe[k][2] <= pipe[k][1];
      end
   end
   assign mdout[0] = pipe[0][0];
   assign mdout[1] = pipe[1][2];

   always @(posedge clk) begin
      if (men[0]) npulse[0] <= npulse[0] + 1;
      if (men[1]) npulse[1] <= npulse[1] + 1;
   end

   // Timeline model: age counts cycles since grant (1 = issue cycle); done falls at age dur.
   bit          m_busy[2], m_rw[2];
   int          m_age[2], m_port[2], m_prio[2];
   logic [14:0] m_addr[2];
   logic [31:0] m_data[2], m_do1[2], m_do2[2];
   logic [31:0] ref_mem [2][32768];

   function automatic int dur(input int k);
      return m_rw[k] ? 2 : 2 + rl(k);
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               m_busy[k] = 1'b0; m_rw[k] = 1'b0; m_age[k] = 0; m_port[k] = 1; m_prio[k] = 1;
               m_addr[k] = '0; m_data[k] = '0; m_do1[k] = '0; m_do2[k] = '0;
            end else if (m_busy[k]) begin
               if (m_age[k] == dur(k)) begin
                  m_busy[k] = 1'b0;
                  m_prio[k] = (m_port[k] == 1) ? 2 : 1;
               end else begin
                  m_age[k]++;
                  if (m_age[k] == dur(k) && !m_rw[k]) begin
                     if (m_port[k] == 1) m_do1[k] = ref_mem[k][m_addr[k]];
                     else                m_do2[k] = ref_mem[k][m_addr[k]];
                  end
               end
            end else if (me[k] && (en1[k] || en2[k])) begin
`ifdef MEMARB_FIXED_PRIORITY_EN
               m_port[k] = en1[k] ? 1 : 2;
`else
               m_port[k] = (en1[k] && en2[k]) ? m_prio[k] : (en1[k] ? 1 : 2);
`endif
               m_busy[k] = 1'b1;
               m_age[k]  = 1;
               m_rw[k]   = (m_port[k] == 1) ? rw1[k] : rw2[k];
               m_addr[k] = (m_port[k] == 1) ? a1[k]  : a2[k];
               m_data[k] = (m_port[k] == 1) ? d1[k]  : d2[k];
               if (m_rw[k]) ref_mem[k][m_addr[k]] = m_data[k];
            end
         end
      end
   end

   // Per-cycle compare of every output against the model.
   initial begin
      logic [114:0] act, exp;
      logic e_men, e_d1, e_d2;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
               e_men = m_busy[k] && (m_age[k] == 1);
               e_d1  = m_busy[k] && (m_age[k] == dur(k)) && (m_port[k] == 1);
               e_d2  = m_busy[k] && (m_age[k] == dur(k)) && (m_port[k] == 2);
               act = {men[k], mrw[k], maddr[k], mdin[k], do1[k], do2[k], dn1[k], dn2[k]};
               exp = {e_men, m_rw[k], m_addr[k], m_data[k], m_do1[k], m_do2[k], e_d1, e_d2};
               vectors++;
               if (act !== exp) begin
                  errs++;
                  $display("FAIL outputs inst=%0d cyc=%0d: got %h expected %h", k, cyc, act, exp);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input int k, input int p, input bit on, input bit rw,
                          input logic [14:0] a, input logic [31:0] d);
      if (p == 1) begin en1[k] = on; rw1[k] = rw; a1[k] = a; d1[k] = d; end
      else        begin en2[k] = on; rw2[k] = rw; a2[k] = a; d2[k] = d; end
   endtask

   // Waits for port p's done (called at posedge+1), drops the request, returns cycles since s.
   task automatic wait_done(input int k, input int p, input int s, output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if ((p == 1) ? dn1[k] : dn2[k]) begin
            lat = cyc - s;
            if (p == 1) en1[k] = 1'b0; else en2[k] = 1'b0;
            break;
         end
      end
      if (lat < 0) begin
         vectors++; errs++;
         $display("FAIL timeout inst=%0d port=%0d: got no done expected done within 40 cycles", k, p);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   initial begin
      int s, lat, n, got;
      int seq[4];
      int exp_seq[4];
      int snap;
`ifdef MEMARB_FIXED_PRIORITY_EN
      exp_seq = '{1, 1, 1, 1};
`else
      exp_seq = '{1, 2, 1, 2};
`endif
      for (int k = 0; k < 2; k++) begin
         me[k] = 1'b1; en1[k] = 0; en2[k] = 0; rw1[k] = 0; rw2[k] = 0;
         a1[k] = '0; a2[k] = '0; d1[k] = '0; d2[k] = '0;
      end
      #2 rst = 1'b1;
      chk_on = 1'b1;
      @(posedge clk); #1;
      check("rst_mem_enable", 32'(men[0]), 32'd0);
      check("rst_mem_address", 32'(maddr[1]), 32'd0);
      check("rst_dataout1", do1[0], 32'd0);
      check("rst_done", {30'd0, dn1[1], dn2[1]}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // Single write, port 1.
      set_req(0, 1, 1'b1, 1'b1, 15'h0010, 32'hDEADBEEF); s = cyc;
      wait_done(0, 1, s, lat);
      check("wr_done_latency", lat, 2);
      check("wr_issue_pulses", npulse[0], 1);
      idle(2);

      // Port 2 reads it back with latency 1.
      set_req(0, 2, 1'b1, 1'b0, 15'h0010, 32'h0); s = cyc;
      wait_done(0, 2, s, lat);
      check("rd_done_latency", lat, 3);
      check("rd_dataout2", do2[0], 32'hDEADBEEF);
      check("rd_dataout1_held", do1[0], 32'd0);
      idle(2);

      // Both ports write continuously.
      set_req(0, 1, 1'b1, 1'b1, 15'h0100, 32'hA1A1A1A1);
      set_req(0, 2, 1'b1, 1'b1, 15'h0200, 32'hB2B2B2B2);
      n = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(posedge clk); #1;
         if (dn1[0])      begin seq[n] = 1; n++; end
         else if (dn2[0]) begin seq[n] = 2; n++; end
      end
      en1[0] = 1'b0; en2[0] = 1'b0;
      check("rr_count", n, 4);
      for (int i = 0; i < 4 && i < n; i++) check($sformatf("rr_grant%0d", i), seq[i], exp_seq[i]);
      idle(2);

      // moduleEnable low blocks new grants.
      me[0] = 1'b0;
      set_req(0, 1, 1'b1, 1'b1, 15'h0040, 32'h11111111);
      set_req(0, 2, 1'b1, 1'b1, 15'h0050, 32'h22222222);
      snap = npulse[0];
      idle(10);
      check("disabled_no_issue", npulse[0], snap);
      me[0] = 1'b1;
      @(posedge clk); #1;
      check("enable_issue", 32'(men[0]), 32'd1);
      check("enable_port1_addr", 32'(maddr[0]), 32'h0040);
      @(posedge clk); #1;
      check("enable_done1", 32'(dn1[0]), 32'd1);
      en1[0] = 1'b0; en2[0] = 1'b0;
      idle(3);

      // Latency 3: write then read on port 1, address changed mid-access.
      set_req(1, 1, 1'b1, 1'b1, 15'h0123, 32'h12345678); s = cyc;
      wait_done(1, 1, s, lat);
      idle(2);
      set_req(1, 1, 1'b1, 1'b0, 15'h0123, 32'h0); s = cyc;
      idle(2);
      a1[1] = 15'h7FFF;
      check("addr_change_ignored", 32'(maddr[1]), 32'h0123);
      wait_done(1, 1, s, lat);
      check("rl3_done_latency", lat, 5);
      check("rl3_dataout1", do1[1], 32'h12345678);
      idle(2);

      // Reset in the middle of a port 2 read.
      set_req(1, 2, 1'b1, 1'b0, 15'h0123, 32'h0);
      idle(3);
      rst = 1'b1;
      #1;
      check("midrst_mem_enable", 32'(men[1]), 32'd0);
      check("midrst_done2", 32'(dn2[1]), 32'd0);
      check("midrst_dataout1", do1[1], 32'd0);
      check("midrst_address", 32'(maddr[1]), 32'd0);
      en2[1] = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(1);
      set_req(1, 1, 1'b1, 1'b1, 15'h0300, 32'h33333333);
      set_req(1, 2, 1'b1, 1'b1, 15'h0400, 32'h44444444);
      s = cyc; got = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (dn1[1] || dn2[1]) begin got = dn1[1] ? 1 : 2; break; end
      end
      en1[1] = 1'b0; en2[1] = 1'b0;
      check("postrst_winner", got, 1);
      check("postrst_latency", cyc - s, 2);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
